alu_seq_n: RTL and testbench
============================

Name: alu_seq_n

Overview:
- Parametrised successor to the 4-bit push-button ALU.
- W-bit operand/op-select registers are loaded from a shared input bus, as in the original board flow, and a start/busy/done handshake is added.
- Executes add/sub/and/or/xor in one cycle and an optional multi-cycle shift-add unsigned multiply.
- Registered result and flags feed the LCD print block or downstream logic.

Parameters:
- W, 4: operand/result width; legal values 2..16.
- SUB_MAG, 1: 1 = SUB reports the magnitude in res, with sign in sf; 0 = SUB reports the raw two's-complement value in res.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- din  in  W  shared load bus
- load_a  in  1  load operand A from din
- load_b  in  1  load operand B from din
- load_op  in  1  load op register from din[2:0]
- start  in  1  begin operation on the held A, B and op
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when res and flags are updated
- res  out  W  result; low half of the product for MUL
- res_hi  out  W  high half of the product for MUL; 0 for all other ops
- cout  out  1  carry (ADD), no-borrow (SUB), |res_hi (MUL)
- ovf  out  1  signed overflow (ADD/SUB only)
- zf  out  1  final reported result == 0 (for MUL, the full 2W product)
- sf  out  1  sign flag
- err  out  1  illegal or disabled op executed

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-high.
  - On rst: A, B and op clear to 0; FSM goes to IDLE; all outputs are 0.
  - Reset overrides every other input, including mid-multiply: the partial product is discarded and no done pulse is issued.
- Loads:
  - Priority is load_a > load_b > load_op; at most one register is written per cycle.
  - Loads are ignored while busy=1.
  - Loads are also ignored in any cycle where start is accepted, so start wins and uses the pre-existing register values.
- Op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 illegal.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE + start: go to EXEC (op != 101) or MUL (op == 101); busy rises the next cycle.
  - EXEC: one cycle; outputs are computed and registered; go to DONE.
  - MUL: W iterations of shift-add (test B bit i, add A<<i into a 2W-bit accumulator); then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
  - start is ignored while busy.
- Latency, with start sampled at edge t:
  - Single-cycle ops: done is high in cycle t+2.
  - MUL: done is high in cycle t+W+2.
- Output updates:
  - res and flags update in the same cycle done rises.
  - They hold until the next done or reset.
- ADD:
  - {cout,res} = A+B, at W+1 bits.
  - ovf = (A[W-1]==B[W-1]) && (res[W-1]!=A[W-1]).
  - sf = res[W-1].
- SUB:
  - raw = A + ~B + 1; cout = carry out of that sum (1 = no borrow).
  - ovf = (A[W-1]!=B[W-1]) && (raw[W-1]!=A[W-1]).
  - sf = raw[W-1].
  - With SUB_MAG=1 and sf=1, res = -raw mod 2^W. The most-negative raw value therefore reports res = 2^(W-1).
- Logic ops (AND/OR/XOR): cout=0, ovf=0, sf=0.
- MUL: unsigned; {res_hi,res} = A*B; ovf=0; sf=0.
- Flags common to all ops:
  - zf is computed on the final reported value.
  - err=0 for all legal ops.
- Illegal op: res=0, res_hi=0, zf=1, err=1, all other flags 0; timing is the same as a single-cycle op.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- When defined:
  - The MUL state, datapath and 2W-bit accumulator are built.
  - op 101 multiplies as specified above.
- When undefined:
  - No MUL state or accumulator is built.
  - op 101 is treated as illegal: err=1, res=0, res_hi=0, zf=1, single-cycle latency.
  - The res_hi port remains and is tied to 0.

Test Plan:
- W=4, A=7, B=1, op=ADD, start -> two cycles later: res=1000, cout=0, ovf=1, sf=1, zf=0, done pulses once.
- W=4, A=F, B=1, ADD -> res=0, cout=1, zf=1, ovf=0. Then op=SUB with A=3, B=5, SUB_MAG=1 -> res=0010, sf=1, cout=0, ovf=0. Repeat with SUB_MAG=0 -> res=1110.
- W=4, A=8, B=1, SUB, SUB_MAG=1 -> raw=0111, ovf=1, sf=0, res=0111. Then A=0, B=8 -> raw=1000, sf=1, res=1000 (magnitude wrap), ovf=1.
- W=4 with ALU_SEQ_MUL_EN: A=F, B=F, MUL -> busy for W+1 cycles, done at t+6, res=1, res_hi=E, cout=1, zf=0. In the same build, pulse load_a and start while busy -> A unchanged and no second done.
- W=8, A=0x35, B=0x0F: AND -> 0x05; OR -> 0x3F; XOR -> 0x3A. Each gives done at t+2 with cout=ovf=sf=0. Then op=110 -> err=1, zf=1, res=0.
- Assert rst at MUL iteration 2 -> next cycle all outputs 0, busy=0, no done, A=B=op=0. A subsequent ADD 2+3 -> res=5.
- Build without ALU_SEQ_MUL_EN: op=101 -> err=1, res_hi=0, done at t+2.

Source files
------------

// File: rtl/alu_seq_n.sv
// alu_seq_n: W-bit sequential ALU with a shared load bus and a start/busy/done handshake.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add unsigned multiplier (op 101).
module alu_seq_n #(
  parameter int unsigned W       = 4,
  parameter int unsigned SUB_MAG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         load_a,
  input  logic         load_b,
  input  logic         load_op,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res,
  output logic [W-1:0] res_hi,
  output logic         cout,
  output logic         ovf,
  output logic         zf,
  output logic         sf,
  output logic         err
);

  localparam int unsigned OP_W = 3;
  localparam int unsigned WP1  = W + 1;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam int unsigned     W2     = 2 * W;
  localparam int unsigned     CNT_W  = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2,
    S_MUL  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;
`endif

  state_e state_q, state_d;

  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            load_en_c;

  logic [W-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic         cout_q, cout_d, ovf_q, ovf_d, zf_q, zf_d;
  logic         sf_q, sf_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

  logic [W:0]   sum_add_c, sum_sub_c;
  logic [W-1:0] raw_sub_c, alu_res_c;
  logic         alu_cout_c, alu_ovf_c, alu_sf_c, alu_err_c;

`ifdef ALU_SEQ_MUL_EN
  logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_SEQ_MUL_EN
          state_d = (op_q == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_EXEC: state_d = S_DONE;
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (cnt_q == CNT_W'(W)) state_d = S_DONE;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand/op loads: blocked while busy and in the cycle a start is accepted
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    load_en_c = ((state_q == S_IDLE) && !start) || (state_q == S_DONE);
    if (load_en_c) begin
      if (load_a)       a_d  = din;
      else if (load_b)  b_d  = din;
      else if (load_op) op_d = OP_W'(din);
    end
  end

  // Single-cycle datapath
  always_comb begin
    sum_add_c  = {1'b0, a_q} + {1'b0, b_q};
    sum_sub_c  = {1'b0, a_q} + {1'b0, ~b_q} + WP1'(1);
    raw_sub_c  = sum_sub_c[W-1:0];
    alu_res_c  = '0;
    alu_cout_c = 1'b0;
    alu_ovf_c  = 1'b0;
    alu_sf_c   = 1'b0;
    alu_err_c  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res_c  = sum_add_c[W-1:0];
        alu_cout_c = sum_add_c[W];
        alu_ovf_c  = (a_q[W-1] == b_q[W-1]) && (sum_add_c[W-1] != a_q[W-1]);
        alu_sf_c   = sum_add_c[W-1];
      end
      OP_SUB: begin
        alu_cout_c = sum_sub_c[W];
        alu_ovf_c  = (a_q[W-1] != b_q[W-1]) && (raw_sub_c[W-1] != a_q[W-1]);
        alu_sf_c   = raw_sub_c[W-1];
        alu_res_c  = ((SUB_MAG != 0) && raw_sub_c[W-1]) ? ((~raw_sub_c) + W'(1)) : raw_sub_c;
      end
      OP_AND:  alu_res_c = a_q & b_q;
      OP_OR:   alu_res_c = a_q | b_q;
      OP_XOR:  alu_res_c = a_q ^ b_q;
      default: alu_err_c = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiplier: one multiplier bit per cycle
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if ((state_q == S_IDLE) && (state_d == S_MUL)) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a_q};
      mplier_d = b_q;
      cnt_d    = '0;
    end else if ((state_q == S_MUL) && (cnt_q != CNT_W'(W))) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end
`endif

  // Output logic: results latch on the transition into DONE
  always_comb begin
    res_d    = res_q;
    res_hi_d = res_hi_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
    busy_d   = (state_d == S_EXEC) || (state_d == S_MUL);
`else
    busy_d   = (state_d == S_EXEC);
`endif
    done_d   = (state_d == S_DONE);
    if (state_q == S_EXEC) begin
      res_d    = alu_res_c;
      res_hi_d = '0;
      cout_d   = alu_cout_c;
      ovf_d    = alu_ovf_c;
      sf_d     = alu_sf_c;
      err_d    = alu_err_c;
      zf_d     = (alu_res_c == '0);
    end
`ifdef ALU_SEQ_MUL_EN
    if ((state_q == S_MUL) && (state_d == S_DONE)) begin
      res_d    = acc_q[W-1:0];
      res_hi_d = acc_q[W2-1:W];
      cout_d   = |acc_q[W2-1:W];
      ovf_d    = 1'b0;
      sf_d     = 1'b0;
      err_d    = 1'b0;
      zf_d     = (acc_q == '0);
    end
`endif
  end

  // State, operand and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign res    = res_q;
  assign res_hi = res_hi_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zf     = zf_q;
  assign sf     = sf_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed vectors for alu_seq_n at W=4 (both SUB_MAG settings) and W=8.
// Expectations follow the ALU_SEQ_MUL_EN setting of the build.
module tb_alu_seq_n;

`ifdef ALU_SEQ_MUL_EN
  localparam int       MUL_LAT = 5;
  localparam int       RST_K   = 2;
  localparam bit       MUL_EN  = 1'b1;
`else
  localparam int       MUL_LAT = 1;
  localparam int       RST_K   = 0;
  localparam bit       MUL_EN  = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_ILL = 3'b110;

  logic       clk, rst, load_a, load_b, load_op, start;
  logic [7:0] din8;

  logic       d4_busy, d4_done, d4_cout, d4_ovf, d4_zf, d4_sf, d4_err;
  logic [3:0] d4_res, d4_res_hi;
  logic       d4r_busy, d4r_done, d4r_cout, d4r_ovf, d4r_zf, d4r_sf, d4r_err;
  logic [3:0] d4r_res, d4r_res_hi;
  logic       d8_busy, d8_done, d8_cout, d8_ovf, d8_zf, d8_sf, d8_err;
  logic [7:0] d8_res, d8_res_hi;

  int vec_cnt = 0;
  int miss_cnt = 0;

  alu_seq_n #(.W(4), .SUB_MAG(1)) u_dut4 (
    .clk(clk), .rst(rst), .din(din8[3:0]), .load_a(load_a), .load_b(load_b),
    .load_op(load_op), .start(start), .busy(d4_busy), .done(d4_done), .res(d4_res),
    .res_hi(d4_res_hi), .cout(d4_cout), .ovf(d4_ovf), .zf(d4_zf), .sf(d4_sf), .err(d4_err)
  );

  alu_seq_n #(.W(4), .SUB_MAG(0)) u_dut4r (
    .clk(clk), .rst(rst), .din(din8[3:0]), .load_a(load_a), .load_b(load_b),
    .load_op(load_op), .start(start), .busy(d4r_busy), .done(d4r_done), .res(d4r_res),
    .res_hi(d4r_res_hi), .cout(d4r_cout), .ovf(d4r_ovf), .zf(d4r_zf), .sf(d4r_sf), .err(d4r_err)
  );

  alu_seq_n #(.W(8), .SUB_MAG(1)) u_dut8 (
    .clk(clk), .rst(rst), .din(din8), .load_a(load_a), .load_b(load_b),
    .load_op(load_op), .start(start), .busy(d8_busy), .done(d8_done), .res(d8_res),
    .res_hi(d8_res_hi), .cout(d8_cout), .ovf(d8_ovf), .zf(d8_zf), .sf(d8_sf), .err(d8_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {res, res_hi, cout, ovf, zf, sf, err}
  wire [12:0] d4_obs  = {d4_res, d4_res_hi, d4_cout, d4_ovf, d4_zf, d4_sf, d4_err};
  wire [12:0] d4r_obs = {d4r_res, d4r_res_hi, d4r_cout, d4r_ovf, d4r_zf, d4r_sf, d4r_err};
  wire [20:0] d8_obs  = {d8_res, d8_res_hi, d8_cout, d8_ovf, d8_zf, d8_sf, d8_err};

  task automatic do_load(input int sel, input logic [7:0] val);
    @(negedge clk);
    din8    = val;
    load_a  = (sel == 0);
    load_b  = (sel == 1);
    load_op = (sel == 2);
    @(negedge clk);
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    do_load(0, a);
    do_load(1, b);
    do_load(2, {5'd0, op});
  endtask

  // Pulses start, returns cycles from the start edge to done, busy just after start, and extra dones
  task automatic start_wait(output int lat, output logic busy0, output int extra);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy0 = d4_busy;
    lat   = -1;
    for (int k = 0; k < 40; k++) begin
      if (d4_done) begin lat = k; break; end
      @(negedge clk);
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d4_done) extra++;
    end
    for (int k = 0; k < 40 && (d4_busy || d4r_busy || d8_busy); k++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({d4_obs, d4_busy, d4_done} !== 15'd0) begin
      miss_cnt++; $display("FAIL reset_w4: got %h want 0", {d4_obs, d4_busy, d4_done});
    end
    vec_cnt++;
    if ({d8_obs, d8_busy, d8_done} !== 23'd0) begin
      miss_cnt++; $display("FAIL reset_w8: got %h want 0", {d8_obs, d8_busy, d8_done});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, extra; logic busy0;
    load_all(8'h07, 8'h01, OP_ADD);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (lat != 1 || busy0 !== 1'b1 || extra != 0) begin
      miss_cnt++; $display("FAIL add_timing: lat=%0d busy=%b extra=%0d want lat=1 busy=1 extra=0", lat, busy0, extra);
    end
    vec_cnt++;
    if (d4_obs !== {4'h8, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miss_cnt++; $display("FAIL add_7p1: got %h want %h", d4_obs, {4'h8, 4'h0, 5'b01010});
    end
    load_all(8'h0F, 8'h01, OP_ADD);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (d4_obs !== {4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miss_cnt++; $display("FAIL add_fp1: got %h want %h", d4_obs, {4'h0, 4'h0, 5'b10100});
    end
  endtask

  task automatic test_sub();
    int lat, extra; logic busy0;
    load_all(8'h03, 8'h05, OP_SUB);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (d4_obs !== {4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miss_cnt++; $display("FAIL sub_3m5_mag: got %h want %h", d4_obs, {4'h2, 4'h0, 5'b00010});
    end
    vec_cnt++;
    if (d4r_obs !== {4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miss_cnt++; $display("FAIL sub_3m5_raw: got %h want %h", d4r_obs, {4'hE, 4'h0, 5'b00010});
    end
    load_all(8'h08, 8'h01, OP_SUB);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (d4_obs !== {4'h7, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miss_cnt++; $display("FAIL sub_8m1: got %h want %h", d4_obs, {4'h7, 4'h0, 5'b11000});
    end
    load_all(8'h00, 8'h08, OP_SUB);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (d4_obs !== {4'h8, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miss_cnt++; $display("FAIL sub_0m8_wrap: got %h want %h", d4_obs, {4'h8, 4'h0, 5'b01010});
    end
  endtask

  task automatic test_mul();
    int lat, extra; logic busy0;
    load_all(8'h0F, 8'h0F, OP_MUL);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (lat != MUL_LAT || busy0 !== 1'b1 || extra != 0) begin
      miss_cnt++; $display("FAIL mul_timing: lat=%0d busy=%b extra=%0d want lat=%0d busy=1 extra=0", lat, busy0, extra, MUL_LAT);
    end
    vec_cnt++;
    if (MUL_EN) begin
      if (d4_obs !== {4'h1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        miss_cnt++; $display("FAIL mul_fxf: got %h want %h", d4_obs, {4'h1, 4'hE, 5'b10000});
      end
    end else begin
      if (d4_obs !== {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
        miss_cnt++; $display("FAIL mul_disabled: got %h want %h", d4_obs, {4'h0, 4'h0, 5'b00101});
      end
    end
  endtask

  task automatic test_logic_w8();
    int lat, extra; logic busy0;
    logic [2:0] ops [4] = '{OP_AND, OP_OR, OP_XOR, OP_ILL};
    logic [20:0] exp [4] = '{{8'h05, 8'h00, 5'b00000}, {8'h3F, 8'h00, 5'b00000},
                             {8'h3A, 8'h00, 5'b00000}, {8'h00, 8'h00, 5'b00101}};
    load_all(8'h35, 8'h0F, OP_AND);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) do_load(2, {5'd0, ops[i]});
      start_wait(lat, busy0, extra);
      vec_cnt++;
      if (lat != 1 || d8_obs !== exp[i]) begin
        miss_cnt++; $display("FAIL logic_w8_op%0d: lat=%0d got %h want lat=1 %h", ops[i], lat, d8_obs, exp[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, extra, dcnt; logic busy0;
    load_all(8'h0F, 8'h0F, MUL_EN ? OP_MUL : OP_ADD);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vec_cnt++;
    if (d4_busy !== 1'b1) begin
      miss_cnt++; $display("FAIL busy_high: got %b want 1", d4_busy);
    end
    din8 = 8'h03; load_a = 1'b1; start = 1'b1;
    @(negedge clk);
    load_a = 1'b0; start = 1'b0;
    dcnt = d4_done ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (d4_done) dcnt++;
    end
    vec_cnt++;
    if (dcnt != 1) begin
      miss_cnt++; $display("FAIL busy_single_done: got %0d dones want 1", dcnt);
    end
    do_load(2, {5'd0, OP_ADD});
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (d4_obs !== {4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miss_cnt++; $display("FAIL busy_a_kept: got %h want %h", d4_obs, {4'hE, 4'h0, 5'b10010});
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, extra, dcnt; logic busy0;
    load_all(8'h0F, 8'h0F, MUL_EN ? OP_MUL : OP_ADD);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (RST_K) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({d4_obs, d4_busy, d4_done} !== 15'd0) begin
      miss_cnt++; $display("FAIL midrst_outputs: got %h want 0", {d4_obs, d4_busy, d4_done});
    end
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d4_done) dcnt++;
    end
    vec_cnt++;
    if (dcnt != 0) begin
      miss_cnt++; $display("FAIL midrst_no_done: got %0d dones want 0", dcnt);
    end
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (lat != 1 || d4_obs !== {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miss_cnt++; $display("FAIL midrst_regs_cleared: lat=%0d got %h want lat=1 %h", lat, d4_obs, {4'h0, 4'h0, 5'b00100});
    end
    load_all(8'h02, 8'h03, OP_ADD);
    start_wait(lat, busy0, extra);
    vec_cnt++;
    if (d4_obs !== {4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miss_cnt++; $display("FAIL midrst_add_2p3: got %h want %h", d4_obs, {4'h5, 4'h0, 5'b00000});
    end
  endtask

  initial begin
    rst = 1'b1; din8 = 8'h00; load_a = 1'b0; load_b = 1'b0; load_op = 1'b0; start = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_logic_w8();
    test_busy_ignore();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
